// File: rtl/tpu_pkg.sv
// Shared TPU definitions.
//
// Contents:
//   ACT_DATA_W       canonical activation element width
//   act_pair_t       one unified-buffer vector for the 2-row array: {last, row1, row0}
//   skew_state_e     activation skew feeder FSM states
//   ST_*             logic-typed state constants for state registers
//   next_skew_state  next-state rule of the skew feeder, evaluated on advancing edges
package tpu_pkg;

    localparam int ACT_DATA_W = 8;

    typedef struct packed {
        logic                  last;
        logic [ACT_DATA_W-1:0] row1;
        logic [ACT_DATA_W-1:0] row0;
    } act_pair_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_STREAM = STREAM;
    localparam logic [1:0] ST_DRAIN  = DRAIN;

    // A pop always decides the state from its last flag. Without a pop,
    // DRAIN has finished handing its final row1 to the delay stage and
    // returns to IDLE; STREAM keeps streaming bubbles until more data arrives.
    function automatic logic [1:0] next_skew_state(input logic [1:0] cur,
                                                   input logic       pop,
                                                   input logic       last);
        logic [1:0] nxt;
        nxt = cur;
        if (pop) begin
            nxt = last ? ST_DRAIN : ST_STREAM;
        end else if (cur == ST_DRAIN) begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/activation_skew_feeder_fifo.sv
// skew_fifo: small synchronous, non-fall-through FIFO.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write request; ignored while full
//   pop,  pop_data    read request; pop_data shows the head entry whenever non-empty
//   full, empty       status from the registered occupancy count
//   count             registered occupancy (0..DEPTH)
//
// A word written on an edge is only visible as the head after that edge, so
// the earliest pop is one cycle after the push. The head is read
// asynchronously from the storage array: the consumer pops and uses the
// data on the same edge, and the array is only a handful of entries deep.
module skew_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage carries no reset; stale entries are never visible because the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/activation_skew_feeder.sv
// activation_skew_feeder: buffers row-aligned activation pairs and feeds them
// diagonally skewed into a 2-row systolic array (row 1 lags row 0 by exactly
// one advancing edge).
//
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   in_valid/in_ready         upstream handshake (in_ready = FIFO not full, low in reset)
//   in_row0, in_row1, in_last activation pair and end-of-batch flag
//   out_ready                 array advance enable; low freezes the skew pipeline
//   skew_valid0/skew_row0     array row 0 input
//   skew_valid1/skew_row1     array row 1 input (one cycle behind row 0)
//   batch_done                qualifies skew_valid1 as the last pair's row 1
//   busy                      FSM not IDLE or FIFO non-empty
//
// Build option SKEW_ZERO_FILL_EN: when defined, bubble cycles also force the
// row data to zero; otherwise the data registers hold and only the valids drop.
module activation_skew_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_W     = ACT_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_row0,
    input  logic [DATA_W-1:0] in_row1,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              skew_valid0,
    output logic [DATA_W-1:0] skew_row0,
    output logic              skew_valid1,
    output logic [DATA_W-1:0] skew_row1,
    output logic              batch_done,
    output logic              busy
);

    // Same layout as act_pair_t, sized by this instance's DATA_W.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] row1;
        logic [DATA_W-1:0] row0;
    } pair_t;

    pair_t                         push_pair;
    pair_t                         head_pair;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          push;
    logic                          pop;

    logic [1:0]                    state_reg;
    logic                          skew_valid0_reg;
    logic [DATA_W-1:0]             skew_row0_reg;
    logic                          dly_valid_reg;
    logic                          dly_last_reg;
    logic [DATA_W-1:0]             row1_dly_reg;
    logic                          skew_valid1_reg;
    logic [DATA_W-1:0]             skew_row1_reg;
    logic                          batch_done_reg;

    // Holding in_ready low during reset keeps upstream from handing over a
    // pair that the reset would silently drop.
    assign in_ready  = !fifo_full && !reset;
    assign push      = in_valid && in_ready;
    assign pop       = out_ready && !fifo_empty;
    assign push_pair = '{last: in_last, row1: in_row1, row0: in_row0};

    skew_fifo #(
        .WIDTH ($bits(pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_pair),
        .pop       (pop),
        .pop_data  (head_pair),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Every register only moves on an advancing edge, so a stall freezes
    // row 0, the delay stage and row 1 together and the skew stays one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            skew_valid0_reg <= 1'b0;
            skew_row0_reg   <= '0;
            dly_valid_reg   <= 1'b0;
            dly_last_reg    <= 1'b0;
            row1_dly_reg    <= '0;
            skew_valid1_reg <= 1'b0;
            skew_row1_reg   <= '0;
            batch_done_reg  <= 1'b0;
        end else if (out_ready) begin
            state_reg       <= next_skew_state(state_reg, pop, head_pair.last);
            skew_valid0_reg <= pop;
            dly_valid_reg   <= pop;
            dly_last_reg    <= pop && head_pair.last;
            skew_valid1_reg <= dly_valid_reg;
            batch_done_reg  <= dly_valid_reg && dly_last_reg;
`ifdef SKEW_ZERO_FILL_EN
            skew_row0_reg   <= pop ? head_pair.row0 : '0;
            row1_dly_reg    <= pop ? head_pair.row1 : '0;
            skew_row1_reg   <= row1_dly_reg;
`else
            if (pop) begin
                skew_row0_reg <= head_pair.row0;
                row1_dly_reg  <= head_pair.row1;
            end
            if (dly_valid_reg) begin
                skew_row1_reg <= row1_dly_reg;
            end
`endif
        end
    end

    assign skew_valid0 = skew_valid0_reg;
    assign skew_row0   = skew_row0_reg;
    assign skew_valid1 = skew_valid1_reg;
    assign skew_row1   = skew_row1_reg;
    assign batch_done  = batch_done_reg;
    assign busy        = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_activation_skew_feeder.sv
module tb_activation_skew_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_row0;
    logic [7:0] in_row1;
    logic       in_last;
    logic       out_ready;
    logic       skew_valid0;
    logic [7:0] skew_row0;
    logic       skew_valid1;
    logic [7:0] skew_row1;
    logic       batch_done;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    activation_skew_feeder #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row0     (in_row0),
        .in_row1     (in_row1),
        .in_last     (in_last),
        .out_ready   (out_ready),
        .skew_valid0 (skew_valid0),
        .skew_row0   (skew_row0),
        .skew_valid1 (skew_valid1),
        .skew_row1   (skew_row1),
        .batch_done  (batch_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One line per accepted pair.
    always @(posedge clk) begin
        if (!reset && in_valid && in_ready) begin
            $display("[%0t] push row0=%02h row1=%02h last=%0b", $time, in_row0, in_row1, in_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Data outputs are only compared while their valid is high: with the
    // default build the data registers hold their old value on bubbles.
    task automatic single_pair(input logic [7:0] r0, input logic [7:0] r1, input string nm);
        in_valid = 1'b1; in_row0 = r0; in_row1 = r1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check({nm, "_accept_v0"}, skew_valid0, 1'b0);
        check({nm, "_accept_busy"}, busy, 1'b1);
        tick();
        check({nm, "_e1_v0"}, skew_valid0, 1'b1);
        check({nm, "_e1_row0"}, skew_row0, r0);
        check({nm, "_e1_v1"}, skew_valid1, 1'b0);
        check({nm, "_e1_done"}, batch_done, 1'b0);
        tick();
        check({nm, "_e2_v0"}, skew_valid0, 1'b0);
        check({nm, "_e2_v1"}, skew_valid1, 1'b1);
        check({nm, "_e2_row1"}, skew_row1, r1);
        check({nm, "_e2_done"}, batch_done, 1'b1);
        check({nm, "_e2_busy"}, busy, 1'b0);
        tick();
        check({nm, "_e3_v1"}, skew_valid1, 1'b0);
        check({nm, "_e3_done"}, batch_done, 1'b0);
    endtask

    // Four pairs pushed on consecutive cycles with out_ready high.
    // Pair k is accepted at edge k; its row0 shows after edge k+1 and its
    // row1 (plus batch_done if last) after edge k+2.
    task automatic run_stream(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [3:0] lm, input string nm);
        logic exp_v0;
        logic exp_v1;
        logic exp_bd;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                in_valid = 1'b1;
                in_row0  = b0 + 8'(c);
                in_row1  = b1 + 8'(c);
                in_last  = lm[c];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            tick();
            exp_v0 = (c >= 1) && (c <= 4);
            exp_v1 = (c >= 2) && (c <= 5);
            exp_bd = 1'b0;
            if (exp_v1) begin
                exp_bd = lm[c-2];
            end
            check($sformatf("%s_c%0d_v0", nm, c), skew_valid0, exp_v0);
            if (exp_v0) check($sformatf("%s_c%0d_row0", nm, c), skew_row0, b0 + 8'(c-1));
            check($sformatf("%s_c%0d_v1", nm, c), skew_valid1, exp_v1);
            if (exp_v1) check($sformatf("%s_c%0d_row1", nm, c), skew_row1, b1 + 8'(c-2));
            check($sformatf("%s_c%0d_done", nm, c), batch_done, exp_bd);
        end
    endtask

    initial begin
        int p;
        logic acc;

        reset = 1'b1; in_valid = 1'b0; in_row0 = '0; in_row1 = '0; in_last = 1'b0; out_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_v0", skew_valid0, 1'b0);
        check("rst_v1", skew_valid1, 1'b0);
        check("rst_done", batch_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_row0", skew_row0, 8'h00);
        check("post_rst_row1", skew_row1, 8'h00);

        // Single pair
        single_pair(8'h11, 8'h22, "single");

        // Four-pair stream, last on the 4th
        run_stream(8'h01, 8'h81, 4'b1000, "stream");
        tick();
        check("stream_idle_busy", busy, 1'b0);

        // Fill the FIFO while the array is stalled
        out_ready = 1'b0;
        p = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (p < 4);
            in_row0  = 8'h41 + 8'(p);
            in_row1  = 8'hC1 + 8'(p);
            in_last  = (p == 3);
            acc = in_valid && in_ready;
            tick();
            if (acc) p++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("fill_accepted", p, 4);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_busy", busy, 1'b1);
        check("fill_v0_frozen", skew_valid0, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) check("drain_in_ready", in_ready, 1'b1);
            check($sformatf("drain_c%0d_v0", c), skew_valid0, c <= 3);
            if (c <= 3) check($sformatf("drain_c%0d_row0", c), skew_row0, 8'h41 + 8'(c));
            check($sformatf("drain_c%0d_v1", c), skew_valid1, (c >= 1) && (c <= 4));
            if (c >= 1 && c <= 4) check($sformatf("drain_c%0d_row1", c), skew_row1, 8'hC1 + 8'(c-1));
            check($sformatf("drain_c%0d_done", c), batch_done, c == 4);
        end
        check("drain_busy", busy, 1'b0);

        // Stall mid-stream: three pairs, out_ready low 3 cycles after the 2nd issues
        in_valid = 1'b1; in_row0 = 8'h51; in_row1 = 8'hD1; in_last = 1'b0;
        tick();
        in_row0 = 8'h52; in_row1 = 8'hD2;
        tick();
        in_row0 = 8'h53; in_row1 = 8'hD3; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("stall_pre_v0", skew_valid0, 1'b1);
        check("stall_pre_row0", skew_row0, 8'h52);
        check("stall_pre_v1", skew_valid1, 1'b1);
        check("stall_pre_row1", skew_row1, 8'hD1);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_c%0d_v0", c), skew_valid0, 1'b1);
            check($sformatf("stall_c%0d_row0", c), skew_row0, 8'h52);
            check($sformatf("stall_c%0d_v1", c), skew_valid1, 1'b1);
            check($sformatf("stall_c%0d_row1", c), skew_row1, 8'hD1);
            check($sformatf("stall_c%0d_done", c), batch_done, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        check("resume1_row0", skew_row0, 8'h53);
        check("resume1_v1", skew_valid1, 1'b1);
        check("resume1_row1", skew_row1, 8'hD2);
        check("resume1_done", batch_done, 1'b0);
        tick();
        check("resume2_v0", skew_valid0, 1'b0);
        check("resume2_row1", skew_row1, 8'hD3);
        check("resume2_done", batch_done, 1'b1);
        tick();
        check("resume3_v1", skew_valid1, 1'b0);
        check("resume3_busy", busy, 1'b0);

        // Two back-to-back batches: last on the 2nd and 4th pairs
        run_stream(8'h61, 8'hE1, 4'b1010, "b2b");

        // Reset with three pairs queued
        in_valid = 1'b1; in_row0 = 8'h71; in_row1 = 8'hF1; in_last = 1'b0;
        tick();
        in_row0 = 8'h72; in_row1 = 8'hF2;
        tick();
        out_ready = 1'b0;
        in_row0 = 8'h73; in_row1 = 8'hF3;
        tick();
        in_row0 = 8'h74; in_row1 = 8'hF4;
        tick();
        in_valid = 1'b0;
        check("preq_v0", skew_valid0, 1'b1);
        check("preq_row0", skew_row0, 8'h71);
        check("preq_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        check("qrst_in_ready", in_ready, 1'b0);
        check("qrst_v0", skew_valid0, 1'b0);
        check("qrst_row0", skew_row0, 8'h00);
        check("qrst_v1", skew_valid1, 1'b0);
        check("qrst_row1", skew_row1, 8'h00);
        check("qrst_done", batch_done, 1'b0);
        check("qrst_busy", busy, 1'b0);
        reset = 1'b0; out_ready = 1'b1;
        tick();
        check("qrst_after_in_ready", in_ready, 1'b1);
        check("qrst_after_v0", skew_valid0, 1'b0);
        check("qrst_after_busy", busy, 1'b0);
        single_pair(8'h33, 8'h44, "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
